// File: rtl/timer_cmd_serializer.sv
// timer_cmd_serializer
// Upstream command stage for the serial timer. It accepts a 4-bit delay on a
// valid/ready handshake and shifts the frame 1101,d3,d2,d1,d0 MSB-first onto
// ser_data. It then waits for timer_done and answers with a one-cycle
// timer_ack. A supervision counter raises a sticky err_timeout if done
// never arrives within the nominal duration plus TIMEOUT_MARGIN.
module timer_cmd_serializer #(
    parameter int TIMEOUT_MARGIN = 64,
    parameter int CNT_W          = 15
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       req_valid,
    input  logic [3:0] req_delay,
    output logic       req_ready,
    output logic       ser_data,
    input  logic       timer_done,
    output logic       timer_ack,
    output logic       busy,
    output logic       err_timeout
);

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_SEND      = 2'd1,
        ST_WAIT_DONE = 2'd2,
        ST_ACK       = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] CYCLES_PER_UNIT = CNT_W'(32'd1000);
    localparam logic [CNT_W-1:0] MARGIN          = CNT_W'(TIMEOUT_MARGIN);
    localparam logic [CNT_W-1:0] CNT_ONE         = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_ZERO        = {CNT_W{1'b0}};

    state_t           state_r, state_s;
    logic [7:0]       shreg_r, shreg_s;
    logic [2:0]       bitcnt_r, bitcnt_s;
    logic [CNT_W-1:0] tocnt_r, tocnt_s;
    logic [CNT_W-1:0] limit_r, limit_s;
    logic [CNT_W-1:0] tocnt_inc_s;
    logic             err_r, err_s;

    // Timeout limit: (delay+1) thousand-cycle units plus the margin, kept at
    // CNT_W bits so the worst case (16000 + margin) fits without wrapping.
    function automatic logic [CNT_W-1:0] calc_limit(input logic [3:0] delay);
        logic [CNT_W-1:0] units;
        units = {{(CNT_W-4){1'b0}}, delay} + CNT_ONE;
        return (units * CYCLES_PER_UNIT) + MARGIN;
    endfunction

    // State and datapath registers; async reset returns everything to idle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r  <= ST_IDLE;
            shreg_r  <= 8'd0;
            bitcnt_r <= 3'd0;
            tocnt_r  <= CNT_ZERO;
            limit_r  <= CNT_ZERO;
            err_r    <= 1'b0;
        end else begin
            state_r  <= state_s;
            shreg_r  <= shreg_s;
            bitcnt_r <= bitcnt_s;
            tocnt_r  <= tocnt_s;
            limit_r  <= limit_s;
            err_r    <= err_s;
        end
    end

    // Next-state and next-datapath logic for the IDLE/SEND/WAIT_DONE/ACK flow.
    always_comb begin
        state_s     = state_r;
        shreg_s     = shreg_r;
        bitcnt_s    = bitcnt_r;
        tocnt_s     = tocnt_r;
        limit_s     = limit_r;
        err_s       = err_r;
        tocnt_inc_s = tocnt_r + CNT_ONE;

        case (state_r)
            ST_IDLE: begin
                if (req_valid) begin
                    shreg_s  = {4'b1101, req_delay};
                    bitcnt_s = 3'd7;
                    limit_s  = calc_limit(req_delay);
                    err_s    = 1'b0;
                    state_s  = ST_SEND;
                end else begin
                    state_s  = ST_IDLE;
                end
            end

            ST_SEND: begin
                // The last shift leaves shreg empty, so the line falls to 0
                // together with the move to WAIT_DONE.
                shreg_s = {shreg_r[6:0], 1'b0};
                if (bitcnt_r == 3'd0) begin
                    tocnt_s = CNT_ZERO;
                    state_s = ST_WAIT_DONE;
                end else begin
                    bitcnt_s = bitcnt_r - 3'd1;
                end
            end

            ST_WAIT_DONE: begin
                // done wins over a timeout that would expire on the same edge.
                if (timer_done) begin
                    state_s = ST_ACK;
                end else if (tocnt_inc_s == limit_r) begin
                    tocnt_s = tocnt_inc_s;
                    err_s   = 1'b1;
                    state_s = ST_IDLE;
                end else begin
                    tocnt_s = tocnt_inc_s;
                end
            end

            ST_ACK: begin
                state_s = ST_IDLE;
            end

            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // Outputs are decoded from registered state only, so async reset clears
    // ser_data, busy and timer_ack immediately.
    assign req_ready   = (state_r == ST_IDLE);
    assign busy        = (state_r != ST_IDLE);
    assign timer_ack   = (state_r == ST_ACK);
    assign ser_data    = (state_r == ST_SEND) & shreg_r[7];
    assign err_timeout = err_r;

endmodule

// File: tb/tb_timer_cmd_serializer.sv
// Self-checking bench for timer_cmd_serializer. Expected frames, timeout
// points and handshake outcomes are derived from the protocol rules
// (frame = 1101 followed by delay, limit = (delay+1)*1000 + 64 cycles).
module tb_timer_cmd_serializer;

    logic       clk;
    logic       reset_n;
    logic       req_valid;
    logic [3:0] req_delay;
    logic       req_ready;
    logic       ser_data;
    logic       timer_done;
    logic       timer_ack;
    logic       busy;
    logic       err_timeout;

    int checks;
    int errors;

    timer_cmd_serializer #(
        .TIMEOUT_MARGIN(64),
        .CNT_W(15)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .req_valid  (req_valid),
        .req_delay  (req_delay),
        .req_ready  (req_ready),
        .ser_data   (ser_data),
        .timer_done (timer_done),
        .timer_ack  (timer_ack),
        .busy       (busy),
        .err_timeout(err_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance past one rising edge and settle.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic check_int(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Issue a request and check the first nbits serial bits of its frame.
    task automatic start_frame(input logic [3:0] d, input int nbits,
                               input bit hold, input bit noise);
        logic [7:0] frame;
        frame = {4'b1101, d};
        check("idle_ready", req_ready, 1'b1);
        check("gap_line_low", ser_data, 1'b0);
        req_delay = d;
        req_valid = 1'b1;
        tick();
        if (!hold) req_valid = 1'b0;
        check("accept_busy", busy, 1'b1);
        check("send_not_ready", req_ready, 1'b0);
        check("err_cleared_on_accept", err_timeout, 1'b0);
        for (int i = 0; i < nbits; i++) begin
            if (i > 0) begin
                if (noise) timer_done = 1'($urandom_range(0, 1));
                tick();
                check("send_not_ready", req_ready, 1'b0);
            end
            check("ser_bit", ser_data, frame[7-i]);
        end
        timer_done = 1'b0;
    endtask

    // Drive the end of the frame and the wait phase. done_after is the edge
    // (counted from entering WAIT_DONE) on which timer_done is sampled high;
    // 0 means never.
    task automatic finish_txn(input logic [3:0] d, input int done_after);
        int  lim;
        int  exp_end;
        bit  exp_ack;
        int  glitches;
        lim      = (int'(d) + 1) * 1000 + 64;
        exp_ack  = (done_after >= 1) && (done_after <= lim);
        exp_end  = exp_ack ? done_after : lim;
        glitches = 0;
        tick();
        check("wait_line_low", ser_data, 1'b0);
        check("wait_busy", busy, 1'b1);
        for (int n = 1; n <= exp_end; n++) begin
            timer_done = (n == done_after);
            tick();
            if (n < exp_end) begin
                if (busy !== 1'b1 || timer_ack !== 1'b0 || ser_data !== 1'b0 ||
                    req_ready !== 1'b0 || err_timeout !== 1'b0)
                    glitches++;
            end
        end
        timer_done = 1'b0;
        check_int("wait_phase_clean", glitches, 0);
        check("end_ack", timer_ack, exp_ack);
        check("end_busy", busy, exp_ack);
        check("end_err", err_timeout, !exp_ack);
        check("end_ready", req_ready, !exp_ack);
        if (exp_ack) begin
            tick();
            check("ack_one_cycle", timer_ack, 1'b0);
            check("post_ack_idle", busy, 1'b0);
            check("post_ack_ready", req_ready, 1'b1);
            check("post_ack_err", err_timeout, 1'b0);
        end
    endtask

    task automatic run_txn(input logic [3:0] d, input int done_after,
                           input bit hold, input bit noise);
        start_frame(d, 8, hold, noise);
        finish_txn(d, done_after);
    endtask

    initial begin
        int rd;
        int rlim;
        checks     = 0;
        errors     = 0;
        reset_n    = 1'b0;
        req_valid  = 1'b0;
        req_delay  = 4'h0;
        timer_done = 1'b0;

        // Reset state
        tick();
        tick();
        check("rst_ser", ser_data, 1'b0);
        check("rst_ack", timer_ack, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_err", err_timeout, 1'b0);
        reset_n = 1'b1;
        tick();
        check("rst_ready", req_ready, 1'b1);

        // Delay 0, done after 1000 cycles
        run_txn(4'h0, 1000, 1'b0, 1'b0);
        tick();

        // Delay 15, done after 16000 cycles, just inside limit 16064
        run_txn(4'hF, 16000, 1'b0, 1'b0);
        tick();

        // Delay 2, done never arrives: timeout after 3064 cycles
        run_txn(4'h2, 0, 1'b0, 1'b0);
        tick();
        tick();
        check("err_sticky", err_timeout, 1'b1);
        check("err_idle_ready", req_ready, 1'b1);
        check("err_no_ack", timer_ack, 1'b0);

        // Next request clears the error; done lands on the limit edge itself
        run_txn(4'h1, 2064, 1'b0, 1'b0);
        tick();

        // Back-to-back with req_valid held high
        run_txn(4'h5, 5000, 1'b1, 1'b0);
        run_txn(4'h9, 9000, 1'b1, 1'b0);
        req_valid = 1'b0;
        tick();

        // Randomized transactions with done noise during SEND
        for (int k = 0; k < 3; k++) begin
            rd   = int'($urandom_range(0, 3));
            rlim = (rd + 1) * 1000 + 64;
            run_txn(4'(rd), int'($urandom_range(1, rlim)), 1'b0, 1'b1);
            tick();
        end

        // Reset pulsed during the 3rd SEND bit
        start_frame(4'h6, 3, 1'b0, 1'b0);
        #2 reset_n = 1'b0;
        #1;
        check("async_rst_busy", busy, 1'b0);
        check("async_rst_ser", ser_data, 1'b0);
        check("async_rst_ack", timer_ack, 1'b0);
        tick();
        reset_n = 1'b1;
        tick();
        check("rst_release_ready", req_ready, 1'b1);

        // Reset pulsed while the line is high (4th SEND bit)
        start_frame(4'hA, 4, 1'b0, 1'b0);
        #2 reset_n = 1'b0;
        #1;
        check("async_rst_ser_high", ser_data, 1'b0);
        check("async_rst_busy2", busy, 1'b0);
        tick();
        reset_n = 1'b1;
        tick();

        // Normal transaction after reset recovery
        run_txn(4'h3, 4000, 1'b0, 1'b0);
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/timer_cmd_serializer.md
Name: timer_cmd_serializer

Overview:
- Upstream command stage for the serial fancy-timer block.
- Accepts a 4-bit delay request on a valid/ready handshake and serializes it MSB-first onto the timer's `data` line as the start pattern 1101 followed by delay[3:0].
- Waits for the timer's `done`, then returns a one-cycle `ack` that releases the timer.
- Supervises the transaction with a timeout and reports a sticky error.

Parameters:
- TIMEOUT_MARGIN, default 64: extra cycles allowed beyond the nominal timer duration before a timeout is declared.
- CNT_W, default 15: width of the supervision counter; must hold 16000 + TIMEOUT_MARGIN.

Ports:
- clk  input  1  single clock; all state changes on rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- req_valid  input  1  delay request present.
- req_delay  input  4  requested delay; timer runs (req_delay+1)*1000 cycles.
- req_ready  output  1  block idle and able to accept a request.
- ser_data  output  1  serial line to the timer `data` input.
- timer_done  input  1  timer `done` output.
- timer_ack  output  1  to the timer `ack` input.
- busy  output  1  transaction in progress (not IDLE).
- err_timeout  output  1  sticky timeout flag.

Behaviour:
- All outputs are registered or decoded from registered state.
- Reset (reset_n=0, async) forces: state=IDLE, ser_data=0, timer_ack=0, busy=0, err_timeout=0, shift register=0, counters=0. req_ready=1 once reset is released.
- Reset asserted mid-transaction aborts immediately and ser_data drops to 0 asynchronously. The downstream timer must be reset alongside.
- States: IDLE, SEND, WAIT_DONE, ACK.
- IDLE:
  - req_ready=1, ser_data=0.
  - On edge E0 with req_valid=1: load shreg={4'b1101, req_delay}, set bitcnt=7.
  - Load limit=(req_delay+1)*1000+TIMEOUT_MARGIN, computed at CNT_W bits with no overflow.
  - Clear err_timeout, go to SEND.
- SEND:
  - ser_data=shreg[7]; shreg shifts left one bit per cycle.
  - Line sequence across cycles E0..E8 is 1,1,0,1,d3,d2,d1,d0.
  - After the 8th bit (edge E8): ser_data=0, tocnt=0, go to WAIT_DONE.
  - The timer samples the start pattern at E1–E4 and the delay bits at E5–E8.
  - req_ready=0; req_valid is ignored.
  - timer_done high during SEND is ignored.
- WAIT_DONE:
  - ser_data held at 0; tocnt increments each cycle.
  - If timer_done=1 is sampled: go to ACK. This takes priority over timeout in the same cycle.
  - Else if tocnt==limit: set err_timeout=1, go to IDLE with no ack issued.
- ACK:
  - timer_ack=1 for exactly one cycle, then go to IDLE.
  - Next request acceptable on the following edge.
  - timer_ack is never asserted outside the ACK state.
- busy = (state != IDLE).
- Back-to-back operation: a request held valid in IDLE is accepted on the first IDLE edge. Minimum idle gap between transactions is 1 cycle, which guarantees the line is low before the next preamble.
- err_timeout stays set until reset or the next accepted request.
- ser_data never carries 1101 outside SEND.

Test Plan:
1. Reset released, req_valid=1, req_delay=4'h0 → ser_data=1,1,0,1,0,0,0,0 over the 8 cycles after acceptance; timer_done rises about 1000 cycles later; timer_ack pulses 1 cycle; req_ready returns 1; err_timeout=0.
2. req_delay=4'hF → serial bits 1,1,0,1,1,1,1,1; done after about 16000 cycles; no timeout (limit 16064); single ack pulse.
3. timer_done tied 0, req_delay=4'h2 → exactly 3064 cycles after entering WAIT_DONE, err_timeout=1, state IDLE, timer_ack never asserted; the next request clears err_timeout.
4. timer_done rises on the same cycle tocnt==limit → ACK taken, err_timeout stays 0.
5. req_valid held high continuously with delays 5 then 9 → second preamble starts one cycle after the ACK cycle; the line is low ≥1 cycle between frames; req_ready=0 throughout SEND and WAIT_DONE.
6. reset_n pulsed low during the 3rd SEND bit → ser_data, busy, timer_ack go 0 immediately; after release req_ready=1 and a new delay=4'h3 request completes normally.
